// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI arbiter block.
package spi_pkg;

   localparam int SPI_DATA_W = 8;
   localparam int TIMEOUT_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      BUSY,
      RESP
   } arb_state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: the search begins at ptr and wraps
// from NUM_REQ-1 back to 0. The pointer register lives in the parent.
module spi_rr_arbiter
   import spi_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   logic             found;
   logic [IDX_W-1:0] idx;

   assign any_req = |req;

   // Walk the requesters in priority order starting at ptr; the first hit wins.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int ofs = 0; ofs < NUM_REQ; ofs++) begin
         idx = IDX_W'((int'(ptr) + ofs) % NUM_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI driver among NUM_REQ requesters. Each transfer is one
// full-duplex byte with a dedicated active-low chip select; a watchdog
// aborts a transfer if the driver never raises or never drops busy.
module spi_arbiter
   import spi_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int TIMEOUT_CYC = 255,
   localparam int IDX_W       = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*SPI_DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [SPI_DATA_W-1:0]          rsp_data,
   output logic                           rsp_err,
   output logic [IDX_W-1:0]               grant_id,
   output logic                           spi_start,
   output logic [SPI_DATA_W-1:0]          spi_tx_data,
   input  logic                           spi_busy,
   input  logic [SPI_DATA_W-1:0]          spi_rx_data,
   output logic [NUM_REQ-1:0]             cs_n
);

   localparam logic [TIMEOUT_W-1:0] TMO_MAX = TIMEOUT_W'(TIMEOUT_CYC);

   arb_state_t             state, state_next;
   logic [IDX_W-1:0]       ptr, ptr_next;
   logic [NUM_REQ-1:0]     sel, sel_next;
   logic [TIMEOUT_W-1:0]   tmo_cnt, tmo_cnt_next;

   logic [NUM_REQ-1:0]     req_ready_next, rsp_valid_next, cs_n_next;
   logic [SPI_DATA_W-1:0]  rsp_data_next, spi_tx_data_next, win_data;
   logic                   rsp_err_next, spi_start_next;
   logic [IDX_W-1:0]       grant_id_next;

   logic [NUM_REQ-1:0]     arb_grant;
   logic [IDX_W-1:0]       arb_idx;
   logic                   any_req;

   spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_req   (any_req)
   );

   // Select the tx byte of the requester the arbiter would grant this cycle.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) win_data = req_data[i*SPI_DATA_W +: SPI_DATA_W];
      end
   end

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      state_next       = state;
      ptr_next         = ptr;
      sel_next         = sel;
      tmo_cnt_next     = tmo_cnt;
      req_ready_next   = '0;
      rsp_valid_next   = '0;
      spi_start_next   = 1'b0;
      rsp_data_next    = rsp_data;
      rsp_err_next     = rsp_err;
      spi_tx_data_next = spi_tx_data;
      grant_id_next    = grant_id;
      cs_n_next        = cs_n;
      case (state)
         IDLE: begin
            if (any_req) begin
               sel_next         = arb_grant;
               grant_id_next    = arb_idx;
               spi_tx_data_next = win_data;
               req_ready_next   = arb_grant;
               state_next       = START;
            end
         end
         START: begin
            spi_start_next = 1'b1;
            cs_n_next      = ~sel;
            tmo_cnt_next   = '0;
            state_next     = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (spi_busy) begin
               tmo_cnt_next = '0;
               state_next   = BUSY;
            end else if (tmo_cnt == TMO_MAX) begin
               rsp_data_next = '0;
               rsp_err_next  = 1'b1;
               state_next    = RESP;
            end else begin
               tmo_cnt_next = tmo_cnt + TIMEOUT_W'(1);
            end
         end
         BUSY: begin
            // The driver updates its rx byte on the same edge that drops busy.
            if (!spi_busy) begin
               rsp_data_next = spi_rx_data;
               rsp_err_next  = 1'b0;
               state_next    = RESP;
            end else if (tmo_cnt == TMO_MAX) begin
               rsp_data_next = '0;
               rsp_err_next  = 1'b1;
               state_next    = RESP;
            end else begin
               tmo_cnt_next = tmo_cnt + TIMEOUT_W'(1);
            end
         end
         RESP: begin
            rsp_valid_next = sel;
            cs_n_next      = '1;
            ptr_next       = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, pointer and registered outputs; reset aborts any transfer silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         sel         <= '0;
         tmo_cnt     <= '0;
         req_ready   <= '0;
         rsp_valid   <= '0;
         spi_start   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         spi_tx_data <= '0;
         grant_id    <= '0;
         cs_n        <= '1;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state       <= state_next;
         ptr         <= ptr_next;
         sel         <= sel_next;
         tmo_cnt     <= tmo_cnt_next;
         req_ready   <= req_ready_next;
         rsp_valid   <= rsp_valid_next;
         spi_start   <= spi_start_next;
         rsp_data    <= rsp_data_next;
         rsp_err     <= rsp_err_next;
         spi_tx_data <= spi_tx_data_next;
         grant_id    <= grant_id_next;
         cs_n        <= cs_n_next;
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: requester models, a model SPI driver,
// and a transaction-level scoreboard sampled on the falling clock edge.
module tb_spi_arbiter;

   localparam int N  = 4;
   localparam int TO = 255;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*8-1:0]   req_data;
   logic [N-1:0]     req_ready, rsp_valid, cs_n;
   logic [7:0]       rsp_data, spi_tx_data, spi_rx_data;
   logic             rsp_err, spi_start, spi_busy;
   logic [1:0]       grant_id;

   always #5 clk = ~clk;

   spi_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .grant_id    (grant_id),
      .spi_start   (spi_start),
      .spi_tx_data (spi_tx_data),
      .spi_busy    (spi_busy),
      .spi_rx_data (spi_rx_data),
      .cs_n        (cs_n)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Requester models: 0 idle, 1 asking, 2 waiting for response.
   int          rq_state[N];
   logic [7:0]  rq_byte[N];
   bit          auto_rerq[N];
   bit          rand_mode;
   logic [N-1:0] pulse_mask;

   // Scoreboard.
   bit          xfer_m, cs_on_m, start_next, to_mode;
   int          win_m, ptr_m, rsp_cd, tm_cnt;
   logic [7:0]  tx_m;
   int          grant_log[$];
   int          last_idx, n_xfers;
   logic [7:0]  last_data;
   logic        last_err;

   // Model SPI driver.
   bit          stall, drv_active, use_forced;
   int          drv_cnt, drv_bit;
   logic [7:0]  drv_tx, drv_rx, mosi, forced_rx;

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Winner = asking requester at the smallest rotating distance from the pointer.
   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      int best, best_d, d;
      best   = -1;
      best_d = N;
      for (int i = 0; i < N; i++) begin
         d = (i - p + N) % N;
         if (r[i] && d < best_d) begin
            best_d = d;
            best   = i;
         end
      end
      return best;
   endfunction

   function automatic int log_at(input int k);
      return (k < grant_log.size()) ? grant_log[k] : -1;
   endfunction

   function automatic bit is_quiet();
      bit q;
      q = !xfer_m && !start_next;
      for (int i = 0; i < N; i++) if (rq_state[i] != 0) q = 1'b0;
      return q;
   endfunction

   task automatic model_reset();
      xfer_m = 0; cs_on_m = 0; start_next = 0; to_mode = 0;
      ptr_m = 0; rsp_cd = 0; tm_cnt = 0; drv_active = 0;
      pulse_mask = '0;
      for (int i = 0; i < N; i++) begin
         rq_state[i] = 0;
         auto_rerq[i] = 0;
      end
      grant_log.delete();
      req_valid = '0; req_data = '0; spi_busy = 1'b0; spi_rx_data = '0;
   endtask

   // One clock: check everything the DUT presents, advance models, drive inputs.
   task automatic step();
      logic [N-1:0]   cur_req, exp_ready, exp_cs;
      logic [N*8-1:0] cur_data;
      bit             idle_before, exp_start, rsp_now;
      int             w;
      @(negedge clk);
      cur_req     = req_valid;
      cur_data    = req_data;
      idle_before = !xfer_m;
      exp_start   = start_next;
      start_next  = 0;
      w           = -1;

      exp_ready = '0;
      if (idle_before && cur_req != '0) begin
         w = rr_pick(cur_req, ptr_m);
         exp_ready = onehot(w);
      end
      check("req_ready", req_ready, exp_ready);
      if (w >= 0) begin
         xfer_m = 1; win_m = w; tx_m = cur_data[w*8 +: 8]; start_next = 1;
         grant_log.push_back(w);
         check("grant_id", grant_id, w);
         check("spi_tx_data", spi_tx_data, tx_m);
      end

      check("spi_start", spi_start, exp_start);
      if (exp_start) begin
         cs_on_m = 1; tm_cnt = 0; to_mode = stall;
      end

      rsp_now = 0;
      if (xfer_m && rsp_cd > 0) begin
         rsp_cd--;
         rsp_now = (rsp_cd == 0);
      end
      if (xfer_m && to_mode && cs_on_m) begin
         tm_cnt++;
         if (rsp_valid != '0) begin
            check("timeout_cycles_in_window", (tm_cnt >= TO - 5 && tm_cnt <= TO + 15), 1);
            rsp_now = 1;
         end else if (tm_cnt > TO + 45) begin
            check("timeout_watchdog", rsp_valid, onehot(win_m));
            rsp_now = 1;
         end
      end
      check("rsp_valid", rsp_valid, rsp_now ? onehot(win_m) : '0);
      if (rsp_now) begin
         check("rsp_data", rsp_data, to_mode ? 8'h00 : drv_rx);
         check("rsp_err", rsp_err, to_mode);
         check("rsp_grant_id", grant_id, win_m);
         last_idx = win_m; last_data = rsp_data; last_err = rsp_err; n_xfers++;
         xfer_m = 0; cs_on_m = 0; to_mode = 0; ptr_m = (win_m + 1) % N;
      end
      exp_cs = cs_on_m ? ~onehot(win_m) : '1;
      check("cs_n", cs_n, exp_cs);

      // Model driver: 16 busy cycles, one MOSI bit every 2 cycles, MSB first.
      if (drv_active) begin
         drv_cnt++;
         if (drv_cnt % 2 == 0) begin
            mosi = {mosi[6:0], drv_tx[7-drv_bit]};
            drv_bit++;
         end
         if (drv_bit == 8) begin
            spi_busy = 1'b0; spi_rx_data = drv_rx; drv_active = 0; rsp_cd = 2;
            check("mosi_byte", mosi, tx_m);
         end
      end
      if (spi_start && !stall) begin
         drv_active = 1; drv_tx = spi_tx_data; drv_cnt = 0; drv_bit = 0; mosi = '0;
         drv_rx = use_forced ? forced_rx : 8'($urandom);
         spi_busy = 1'b1;
      end

      for (int i = 0; i < N; i++) begin
         if (rq_state[i] == 1 && req_ready[i]) rq_state[i] = 2;
         else if (rq_state[i] == 2 && rsp_valid[i]) begin
            rq_state[i] = auto_rerq[i] ? 1 : 0;
            rq_byte[i]  = 8'($urandom);
         end else if (rand_mode && rq_state[i] == 0 && $urandom_range(7) == 0) begin
            rq_state[i] = 1;
            rq_byte[i]  = 8'($urandom);
         end else if (rand_mode && rq_state[i] == 1 && $urandom_range(31) == 0) begin
            rq_state[i] = 0;
         end
         req_valid[i]       = (rq_state[i] == 1) || pulse_mask[i];
         req_data[i*8 +: 8] = (rq_state[i] == 1) ? rq_byte[i] : 8'($urandom);
      end
      pulse_mask = '0;
   endtask

   task automatic run_until_quiet(input int max_cyc);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (n < max_cyc && !is_quiet());
      check("settled", is_quiet(), 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_cs_n", cs_n, {N{1'b1}});
      check("rst_spi_start", spi_start, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_spi_tx_data", spi_tx_data, 0);
      check("rst_grant_id", grant_id, 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n, cnt3;
      rst = 1'b1;
      stall = 0; use_forced = 0; rand_mode = 0; n_xfers = 0;
      model_reset();
      repeat (2) @(negedge clk);
      do_reset();

      // Single request from requester 2.
      use_forced = 1; forced_rx = 8'h3C;
      rq_state[2] = 1; rq_byte[2] = 8'hA5;
      run_until_quiet(200);
      check("single_grants", grant_log.size(), 1);
      check("single_winner", log_at(0), 2);
      check("single_idx", last_idx, 2);
      check("single_rx", last_data, 8'h3C);
      check("single_err", last_err, 0);
      use_forced = 0;

      // All four together from reset.
      do_reset();
      for (int i = 0; i < N; i++) begin
         rq_state[i] = 1; rq_byte[i] = 8'($urandom);
      end
      run_until_quiet(400);
      check("all4_grants", grant_log.size(), 4);
      for (int k = 0; k < 4; k++) check("all4_order", log_at(k), k);

      // Fairness between 0 and 1 re-requesting continuously.
      grant_log.delete();
      auto_rerq[0] = 1; auto_rerq[1] = 1;
      rq_state[0] = 1; rq_state[1] = 1;
      n = 0;
      while (grant_log.size() < 6 && n < 2000) begin
         step();
         n++;
      end
      auto_rerq[0] = 0; auto_rerq[1] = 0;
      run_until_quiet(400);
      for (int k = 0; k < 6; k++) check("fair_order", log_at(k), k % 2);

      // Stalled driver triggers the watchdog; next transfer is normal.
      stall = 1;
      rq_state[1] = 1; rq_byte[1] = 8'h5A;
      run_until_quiet(TO + 100);
      check("tmo_idx", last_idx, 1);
      check("tmo_err", last_err, 1);
      check("tmo_data", last_data, 0);
      stall = 0;
      rq_state[1] = 1; rq_byte[1] = 8'h77;
      run_until_quiet(200);
      check("post_tmo_err", last_err, 0);
      check("post_tmo_idx", last_idx, 1);

      // Requester 3 pulses for one cycle mid-transfer and must not be granted.
      grant_log.delete();
      rq_state[0] = 1; rq_byte[0] = 8'h11;
      n = 0;
      while (!drv_active && n < 50) begin
         step();
         n++;
      end
      pulse_mask = 4'b1000;
      run_until_quiet(200);
      cnt3 = 0;
      foreach (grant_log[k]) if (grant_log[k] == 3) cnt3++;
      check("withdrawn_grant3", cnt3, 0);
      check("withdrawn_grants", grant_log.size(), 1);

      // Randomized traffic with withdrawals.
      rand_mode = 1;
      repeat (3000) step();
      rand_mode = 0;
      run_until_quiet(400);

      // Reset during the 4th bit of a transfer from requester 2.
      rq_state[2] = 1; rq_byte[2] = 8'hC3;
      n = 0;
      while (!(drv_active && drv_bit == 3) && n < 300) begin
         step();
         n++;
      end
      check("reached_bit4", drv_bit, 3);
      do_reset();
      for (int i = 0; i < N; i++) begin
         rq_state[i] = 1; rq_byte[i] = 8'($urandom);
      end
      n = 0;
      while (grant_log.size() == 0 && n < 20) begin
         step();
         n++;
      end
      check("post_rst_first", log_at(0), 0);
      run_until_quiet(400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
Shares one SPI_driver instance among NUM_REQ requesters using round-robin arbitration. Each requester gets a dedicated active-low chip select and a one-byte full-duplex transfer. The block sequences the driver: it pulses start, watches the driver's enable (busy) output, captures the received byte and returns it to the granted requester. It also runs a watchdog so a stalled driver cannot hang the bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 255, max cycles in WAIT_BUSY or BUSY before abort (8-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  reset
req_valid  in  NUM_REQ  per-requester transfer request; held until req_ready
req_data  in  NUM_REQ*8  tx byte per requester; requester i uses bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: request i accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: response for requester i
rsp_data  out  8  received byte; valid with rsp_valid
rsp_err  out  1  timeout flag; valid with rsp_valid
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester
spi_start  out  1  to driver SPI_start
spi_tx_data  out  8  to driver data_in
spi_busy  in  1  from driver SPI_EN
spi_rx_data  in  8  from driver data_out
cs_n  out  NUM_REQ  per-slave chip select, active low

Behaviour:
- Reset (rst asynchronous, active-high; clock clk):
  - State IDLE; rr pointer = 0, so requester 0 has top priority.
  - req_ready, rsp_valid, rsp_err, spi_start = 0; rsp_data, spi_tx_data = 0; grant_id = 0; cs_n = all 1.
  - Reset mid-transfer aborts with no response. The driver is reset by the same rst.
- Outputs are registered. No combinational path from input to output.
- States are IDLE, START, WAIT_BUSY, BUSY, RESP.
- IDLE: if any req_valid is high, pick the winner by round-robin.
  - Search starts at the index after the last winner and wraps from NUM_REQ-1 to 0.
  - Latch req_data of the winner into spi_tx_data and latch grant_id.
  - Pulse req_ready[winner] for 1 cycle. Go to START.
  - Simultaneous requests: only one wins per arbitration. The others stay pending.
- START: spi_start = 1 for exactly 1 cycle and cs_n[winner] = 0. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: hold cs_n. When spi_busy = 1, go to BUSY and clear the counter.
- BUSY: when spi_busy = 0, capture spi_rx_data into rsp_data, set rsp_err = 0, go to RESP.
  - The driver updates data_out in the same edge that drops SPI_EN, so the byte is valid when busy is first seen low.
- Timeout: in WAIT_BUSY or BUSY, when the counter reaches TIMEOUT_CYC, go to RESP with rsp_data = 0 and rsp_err = 1.
- RESP:
  - rsp_valid[winner] = 1 for 1 cycle; cs_n = all 1.
  - rr pointer = winner + 1, wrapping at NUM_REQ.
  - Go to IDLE.
- The IDLE cycle after RESP gives cs_n at least 1 cycle high between back-to-back transfers.
- At most one cs_n bit is low at any time. cs_n is low from START through BUSY inclusive.
- A requester dropping req_valid before req_ready is legal and is simply not granted.
- A requester may re-raise req_valid in the cycle after its rsp_valid.
- Latency from req_valid to spi_start is 2 cycles when idle: ready in cycle 1, start in cycle 2.

Decomposition:
- Package spi_pkg holds:
  - SPI_DATA_W = 8
  - the arb_state_t enum (IDLE, START, WAIT_BUSY, BUSY, RESP)
  - TIMEOUT_W = 8
- Sub-module spi_rr_arbiter(NUM_REQ):
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, grant index and any_req.
  - Purely combinational. The pointer register lives in spi_arbiter.

Test Plan:
- Single request: req_valid[2] = 1, req_data[2] = 8'hA5; the model slave returns 8'h3C.
  - Expect req_ready[2] pulse, then spi_start 1 cycle later, and MOSI shifting A5 MSB-first.
  - Expect cs_n = 4'b1011 during the transfer.
  - Expect rsp_valid[2] with rsp_data = 3C and rsp_err = 0.
- All four requests asserted together from reset:
  - Grant order is 0,1,2,3.
  - cs_n is high for at least 1 cycle between transfers, and each rsp returns to the correct index.
- Fairness: requesters 0 and 1 re-request continuously.
  - Grants alternate 0,1,0,1 over 6 transfers; neither is granted twice in a row.
- Timeout: stub spi_busy stuck at 0 after start.
  - After 255 cycles in WAIT_BUSY, expect rsp_valid with rsp_err = 1, rsp_data = 0, and cs_n all 1.
  - The next request then completes normally.
- Reset mid-BUSY: assert rst during the 4th bit.
  - Immediately expect cs_n all 1 and spi_start = 0, with no rsp_valid.
  - After release, requester 0 wins first.
- Withdrawn request: req_valid[3] pulses high for 1 cycle while a transfer is in progress.
  - Expect no req_ready[3] and no grant to 3.
